// File: rtl/mem_ptr_unit_pkg.sv
// Shared types and default widths for the MiniBit memory/pointer unit.
package mem_ptr_unit_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RMW_RD,
    ST_RMW_WR
  } state_e;

endpackage

// File: rtl/mem_ptr_unit_ptr_counter.sv
// Loadable up/down pointer with wrap or saturate at the range ends.
module ptr_counter
  import mem_ptr_unit_pkg::*;
#(
  parameter int unsigned W    = DEF_ADDR_W,
  parameter bit          WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         dir,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (step) begin
      if (dir) begin
        if (cnt_q == '1) cnt_d = WRAP ? '0 : cnt_q;
        else             cnt_d = cnt_q + W'(1);
      end else begin
        if (cnt_q == '0) cnt_d = WRAP ? '1 : cnt_q;
        else             cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_ptr_unit.sv
// MiniBit data memory with instruction/memory pointers, in-place cell +/-1
// and a post-reset clear sweep of the whole array.
module mem_ptr_unit
  import mem_ptr_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter bit          WRAP   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              ip_load,
  input  logic              ip_inc,
  input  logic              mp_load,
  input  logic              mp_step,
  input  logic              mp_dir,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              cell_step,
  output logic [ADDR_W-1:0] addr_out,
  output logic              busy,
  output logic              rd_valid,
  output logic              cell_zero
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic              rmw_dir_q, rmw_dir_d;
  logic [DATA_W-1:0] rmw_data_q, rmw_data_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              cell_zero_q, cell_zero_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;

  logic [ADDR_W-1:0] ptr_ld_val;
  logic [ADDR_W-1:0] mp;

  if (ADDR_W <= DATA_W) begin : g_narrow
    assign ptr_ld_val = bus_in[ADDR_W-1:0];
  end else begin : g_wide
    assign ptr_ld_val = {{(ADDR_W-DATA_W){1'b0}}, bus_in};
  end

  assign busy = (state_q != ST_IDLE);

  ptr_counter #(.W(ADDR_W), .WRAP(1'b1)) u_ip (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ip_load),
    .load_val (ptr_ld_val),
    .step     (ip_inc),
    .dir      (1'b1),
    .cnt      (addr_out)
  );

  // MP is frozen while busy so an in-flight RMW keeps its latched address.
  ptr_counter #(.W(ADDR_W), .WRAP(WRAP)) u_mp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mp_load & ~busy),
    .load_val (ptr_ld_val),
    .step     (mp_step & ~busy),
    .dir      (mp_dir),
    .cnt      (mp)
  );

  assign rd_addr = (state_q == ST_RMW_RD) ? rmw_addr_q : mp;
  assign rd_word = mem[rd_addr];

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_dir_d   = rmw_dir_q;
    rmw_data_d  = rmw_data_q;
    bus_out_d   = bus_out_q;
    rd_valid_d  = 1'b0;
    cell_zero_d = cell_zero_q;
    mem_we      = 1'b0;
    mem_waddr   = mp;
    mem_wdata   = bus_in;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (mem_wr) begin
          mem_we      = 1'b1;
          cell_zero_d = (bus_in == '0);
        end else if (cell_step) begin
          rmw_addr_d = mp;
          rmw_dir_d  = mp_dir;
          state_d    = ST_RMW_RD;
        end else if (mem_rd) begin
          bus_out_d   = rd_word;
          rd_valid_d  = 1'b1;
          cell_zero_d = (rd_word == '0);
        end
      end
      ST_RMW_RD: begin
        rmw_data_d = rd_word;
        state_d    = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        mem_we      = 1'b1;
        mem_waddr   = rmw_addr_q;
        mem_wdata   = rmw_dir_q ? rmw_data_q + DATA_W'(1) : rmw_data_q - DATA_W'(1);
        cell_zero_d = (mem_wdata == '0);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      rmw_addr_q  <= '0;
      rmw_dir_q   <= 1'b0;
      rmw_data_q  <= '0;
      bus_out_q   <= '0;
      rd_valid_q  <= 1'b0;
      cell_zero_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_dir_q   <= rmw_dir_d;
      rmw_data_q  <= rmw_data_d;
      bus_out_q   <= bus_out_d;
      rd_valid_q  <= rd_valid_d;
      cell_zero_q <= cell_zero_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus_out   = bus_out_q;
  assign rd_valid  = rd_valid_q;
  assign bus_oe    = rd_valid_q;
  assign cell_zero = cell_zero_q;

endmodule

// File: tb/tb_mem_ptr_unit.sv
// Directed bench for mem_ptr_unit; a wrapping and a saturating instance share stimulus.
module tb_mem_ptr_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       ip_load, ip_inc, mp_load, mp_step, mp_dir, mem_rd, mem_wr, cell_step;

  logic [7:0] bus_out_w, addr_out_w, bus_out_s, addr_out_s;
  logic       bus_oe_w, busy_w, rd_valid_w, cell_zero_w;
  logic       bus_oe_s, busy_s, rd_valid_s, cell_zero_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_ptr_unit #(.DATA_W(8), .ADDR_W(8), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .bus_out(bus_out_w), .bus_oe(bus_oe_w),
    .ip_load(ip_load), .ip_inc(ip_inc), .mp_load(mp_load), .mp_step(mp_step),
    .mp_dir(mp_dir), .mem_rd(mem_rd), .mem_wr(mem_wr), .cell_step(cell_step),
    .addr_out(addr_out_w), .busy(busy_w), .rd_valid(rd_valid_w), .cell_zero(cell_zero_w)
  );

  mem_ptr_unit #(.DATA_W(8), .ADDR_W(8), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .bus_out(bus_out_s), .bus_oe(bus_oe_s),
    .ip_load(ip_load), .ip_inc(ip_inc), .mp_load(mp_load), .mp_step(mp_step),
    .mp_dir(mp_dir), .mem_rd(mem_rd), .mem_wr(mem_wr), .cell_step(cell_step),
    .addr_out(addr_out_s), .busy(busy_s), .rd_valid(rd_valid_s), .cell_zero(cell_zero_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_in = 8'h00; ip_load = 0; ip_inc = 0; mp_load = 0; mp_step = 0;
    mp_dir = 0; mem_rd = 0; mem_wr = 0; cell_step = 0;
  endtask

  task automatic load_mp(input logic [7:0] v);
    idle(); bus_in = v; mp_load = 1; tick(); idle();
  endtask

  task automatic write_cell(input logic [7:0] v);
    idle(); bus_in = v; mem_wr = 1; tick(); idle();
  endtask

  // Issues a read and checks the registered result on both instances.
  task automatic read_chk(input string tag, input logic [7:0] exp_w, input logic [7:0] exp_s);
    idle(); mem_rd = 1; tick(); idle();
    chk({tag, "_vld_w"}, {31'd0, rd_valid_w}, 32'd1);
    chk({tag, "_oe_w"}, {31'd0, bus_oe_w}, 32'd1);
    chk({tag, "_dat_w"}, {24'd0, bus_out_w}, {24'd0, exp_w});
    chk({tag, "_cz_w"}, {31'd0, cell_zero_w}, {31'd0, exp_w == 8'h00});
    chk({tag, "_dat_s"}, {24'd0, bus_out_s}, {24'd0, exp_s});
    chk({tag, "_cz_s"}, {31'd0, cell_zero_s}, {31'd0, exp_s == 8'h00});
  endtask

  // Counts edges until busy falls, driving ip_inc on the first n_inc of them.
  task automatic clear_len(input string tag, input int n_inc);
    int cnt = 0;
    while (busy_w && cnt < 400) begin
      ip_inc = (cnt < n_inc);
      tick();
      cnt++;
    end
    ip_inc = 0;
    chk({tag, "_len"}, cnt, 32'd256);
    chk({tag, "_busy_s"}, {31'd0, busy_s}, 32'd0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy_w}, 32'd1);
    chk("rst_ip", {24'd0, addr_out_w}, 32'd0);
    chk("rst_bus", {24'd0, bus_out_w}, 32'd0);
    chk("rst_vld", {31'd0, rd_valid_w}, 32'd0);
    chk("rst_oe", {31'd0, bus_oe_w}, 32'd0);
    chk("rst_cz", {31'd0, cell_zero_w}, 32'd1);
    rst_n = 1'b1;
    clear_len("clr1", 0);

    // Cleared contents at both ends and the middle
    read_chk("rd00", 8'h00, 8'h00);
    load_mp(8'h7F);
    read_chk("rd7f", 8'h00, 8'h00);
    load_mp(8'hFF);
    read_chk("rdff", 8'h00, 8'h00);

    // Write then read back
    load_mp(8'h10);
    write_cell(8'hA5);
    chk("wr_cz", {31'd0, cell_zero_w}, 32'd0);
    chk("wr_novld", {31'd0, rd_valid_w}, 32'd0);
    read_chk("rd10", 8'hA5, 8'hA5);
    tick();
    chk("vld_pulse", {31'd0, rd_valid_w}, 32'd0);

    // IP wrap and load priority
    bus_in = 8'hFE; ip_load = 1; tick(); idle();
    chk("ip_ld", {24'd0, addr_out_w}, 32'hFE);
    ip_inc = 1; tick();
    chk("ip_ff", {24'd0, addr_out_w}, 32'hFF);
    tick(); idle();
    chk("ip_wrap", {24'd0, addr_out_w}, 32'h00);
    bus_in = 8'h40; ip_load = 1; ip_inc = 1; tick(); idle();
    chk("ip_prio", {24'd0, addr_out_w}, 32'h40);

    // MP upper end: wrap to 0 vs hold at 0xFF
    load_mp(8'hFF);
    mp_step = 1; mp_dir = 1; tick(); idle();
    write_cell(8'h11);
    load_mp(8'h00);
    read_chk("up_at0", 8'h11, 8'h00);
    load_mp(8'hFF);
    read_chk("up_atff", 8'h00, 8'h11);
    // MP lower end: wrap to 0xFF vs hold at 0
    load_mp(8'h00);
    mp_step = 1; mp_dir = 0; tick(); idle();
    write_cell(8'h22);
    load_mp(8'hFF);
    read_chk("dn_atff", 8'h22, 8'h11);
    load_mp(8'h00);
    read_chk("dn_at0", 8'h11, 8'h22);

    // In-place increment 0xFF -> 0x00, then decrement back
    load_mp(8'h05);
    write_cell(8'hFF);
    cell_step = 1; mp_dir = 1; tick(); idle();
    chk("inc_busy1", {31'd0, busy_w}, 32'd1);
    tick();
    chk("inc_busy2", {31'd0, busy_w}, 32'd1);
    tick();
    chk("inc_done", {31'd0, busy_w}, 32'd0);
    chk("inc_cz", {31'd0, cell_zero_w}, 32'd1);
    read_chk("inc_rd", 8'h00, 8'h00);
    cell_step = 1; mp_dir = 0; tick(); idle();
    tick(); tick();
    chk("dec_cz", {31'd0, cell_zero_w}, 32'd0);
    read_chk("dec_rd", 8'hFF, 8'hFF);

    // Memory op with simultaneous mp_step uses the old MP
    bus_in = 8'h33; mem_wr = 1; mp_step = 1; mp_dir = 1; tick(); idle();
    read_chk("oldmp_new", 8'h00, 8'h00);
    load_mp(8'h05);
    read_chk("oldmp_old", 8'h33, 8'h33);

    // Write wins over cell_step and read
    bus_in = 8'h44; mem_wr = 1; mem_rd = 1; cell_step = 1; mp_dir = 1; tick(); idle();
    chk("prio_busy", {31'd0, busy_w}, 32'd0);
    chk("prio_vld", {31'd0, rd_valid_w}, 32'd0);
    read_chk("prio_rd", 8'h44, 8'h44);

    // Commands while busy are dropped
    cell_step = 1; mp_dir = 1; tick(); idle();
    bus_in = 8'h20; mp_load = 1; mem_wr = 1; tick();
    idle(); mp_step = 1; mp_dir = 0; tick(); idle();
    chk("busy_ok", {31'd0, busy_w}, 32'd0);
    read_chk("busy_drop", 8'h45, 8'h45);

    // Reset during RMW_WR aborts the step and restarts the sweep
    load_mp(8'h07);
    write_cell(8'h80);
    cell_step = 1; mp_dir = 1; tick(); idle();
    tick();
    rst_n = 1'b0;
    #1;
    chk("ab_busy", {31'd0, busy_w}, 32'd1);
    chk("ab_ip", {24'd0, addr_out_w}, 32'd0);
    chk("ab_cz", {31'd0, cell_zero_w}, 32'd1);
    tick();
    rst_n = 1'b1;
    clear_len("clr2", 3);
    chk("clr_ip", {24'd0, addr_out_w}, 32'd3);
    read_chk("ab_mp0", 8'h00, 8'h00);
    load_mp(8'h07);
    read_chk("ab_rd7", 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
